// File: rtl/bsearch_pkg.sv
// Shared types for the binary-search engine: the controller state encoding.
package bsearch_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_WAIT = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/bsearch_ctrl.sv
// Search sequencer: walks CALC -> WAIT -> CMP per probe and issues the
// init/probe/update strobes that the datapath in the parent acts on.
module bsearch_ctrl
   import bsearch_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic eq,
   input  logic mode,
   input  logic empty,
   output logic init,
   output logic probe,
   output logic update,
   output logic busy,
   output logic done
);

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_CALC;
         S_CALC: state_d = S_WAIT;
         S_WAIT: state_d = S_CMP;
         // An exact-mode hit ends the search even if the interval is still open
         S_CMP: begin
            if ((eq && !mode) || empty) state_d = S_DONE;
            else                        state_d = S_CALC;
         end
         S_DONE: if (!start) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      init   = (state_q == S_IDLE) && start;
      probe  = (state_q == S_CALC);
      update = (state_q == S_CMP);
      busy   = (state_q == S_CALC) || (state_q == S_WAIT) || (state_q == S_CMP);
      done   = (state_q == S_DONE);
   end

endmodule

// File: rtl/bsearch_param.sv
// Binary-search engine over an external sorted, 1-cycle-latency memory.
// Supports exact-match and lower-bound lookups on a half-open [lo, hi) interval.
module bsearch_param
   import bsearch_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] A,
   input  logic              lb_mode,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W:0]   loc
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] target_q, target_d;
   logic              mode_q, mode_d;
   logic [ADDR_W:0]   lo_q, lo_d, hi_q, hi_d, loc_q, loc_d;
   logic [ADDR_W-1:0] mid_q, mid_d;
   logic              found_q, found_d;

   logic              init, probe, update;
   logic              lt, eq, empty;
   logic [ADDR_W+1:0] mid_sum;
   logic [ADDR_W-1:0] mid_calc;
   logic [ADDR_W:0]   mid_ext, mid_inc, lo_upd, hi_upd;

   bsearch_ctrl u_ctrl (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .eq     (eq),
      .mode   (mode_q),
      .empty  (empty),
      .init   (init),
      .probe  (probe),
      .update (update),
      .busy   (busy),
      .done   (done)
   );

   // Candidate interval after this compare; evaluated every cycle so the
   // controller can see the empty-interval condition without a strobe loop.
   always_comb begin
      mid_sum  = {2'b00, lo_q} + {2'b00, hi_q};
      mid_calc = ADDR_W'(mid_sum >> 1);
      mid_ext  = {1'b0, mid_q};
      mid_inc  = mid_ext + 1'b1;
      lt       = (mem_data < target_q);
      eq       = (mem_data == target_q);
      lo_upd   = lt ? mid_inc : lo_q;
      hi_upd   = lt ? hi_q : mid_ext;
      empty    = (lo_upd == hi_upd);
   end

   always_comb begin
      target_d = target_q;
      mode_d   = mode_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      mid_d    = mid_q;
      found_d  = found_q;
      loc_d    = loc_q;
      if (init) begin
         target_d = A;
         mode_d   = lb_mode;
         lo_d     = '0;
         hi_d     = DEPTH;
         found_d  = 1'b0;
      end
      if (probe) mid_d = mid_calc;
      if (update) begin
         if (eq && !mode_q) begin
            found_d = 1'b1;
            loc_d   = mid_ext;
         end else begin
            lo_d = lo_upd;
            hi_d = hi_upd;
            if (eq) found_d = 1'b1;
            if (empty) loc_d = lo_upd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q    <= '0;
         hi_q    <= '0;
         mid_q   <= '0;
         found_q <= 1'b0;
         loc_q   <= '0;
      end else begin
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         mid_q   <= mid_d;
         found_q <= found_d;
         loc_q   <= loc_d;
      end
   end

   always_ff @(posedge clk) begin
      target_q <= target_d;
      mode_q   <= mode_d;
   end

   assign mem_addr = mid_q;
   assign found    = found_q;
   assign loc      = loc_q;

endmodule

// File: tb/tb_bsearch_param.sv
// Directed bench for bsearch_param with a 32x8 synchronous-read memory model.
module tb_bsearch_param;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] A;
   logic       lb_mode;
   logic [4:0] mem_addr;
   logic [7:0] mem_data;
   logic       busy;
   logic       done;
   logic       found;
   logic [5:0] loc;

   logic [7:0] mem [32];
   int checks;
   int failures;

   bsearch_param #(.DATA_W(8), .ADDR_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .A        (A),
      .lb_mode  (lb_mode),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .loc      (loc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
   endtask

   task automatic fill_dup();
      for (int i = 0; i < 32; i++) mem[i] = (i < 5) ? 8'd3 : 8'd7;
   endtask

   // Cycles counted from the edge before start is sampled up to done visible.
   task automatic run_search(input string tag, input logic [7:0] a, input logic m,
                             input logic exp_f, input logic [5:0] exp_loc, input int exp_cyc);
      int   cyc;
      logic overlap;
      logic busy_gap;
      @(negedge clk);
      A = a; lb_mode = m; start = 1'b1;
      cyc = 0; overlap = 1'b0; busy_gap = 1'b0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = 1'b0;
         if (busy && done) overlap = 1'b1;
         if (!busy && !done) busy_gap = 1'b1;
      end while (!done && cyc < 60);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_found"}, 32'(found), 32'(exp_f));
      chk({tag, "_loc"}, 32'(loc), 32'(exp_loc));
      chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
      @(negedge clk);
      chk({tag, "_idle_done"}, 32'(done), 32'd0);
      chk({tag, "_idle_loc_hold"}, 32'(loc), 32'(exp_loc));
   endtask

   initial begin
      int   cyc;
      int   rises;
      int   first_done;
      logic prev_busy;
      logic done_dropped;

      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; A = '0; lb_mode = 1'b0;
      fill_ramp();
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      chk("rst_loc", 32'(loc), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;

      // Ramp memory mem[i] = 2*i
      run_search("ex22", 8'd22, 1'b0, 1'b1, 6'd11, 16);
      run_search("ex23", 8'd23, 1'b0, 1'b0, 6'd12, 16);
      run_search("ex200", 8'd200, 1'b0, 1'b0, 6'd32, 16);
      run_search("ex0", 8'd0, 1'b0, 1'b1, 6'd0, 19);
      run_search("lb22", 8'd22, 1'b1, 1'b1, 6'd11, 16);
      run_search("lb255", 8'd255, 1'b1, 1'b0, 6'd32, 16);

      // Duplicate memory: mem[0..4]=3, rest 7
      fill_dup();
      run_search("lb7", 8'd7, 1'b1, 1'b1, 6'd5, 16);
      run_search("lb5", 8'd5, 1'b1, 1'b0, 6'd5, 16);
      run_search("ex7", 8'd7, 1'b0, 1'b1, 6'd16, 4);
      run_search("ex5", 8'd5, 1'b0, 1'b0, 6'd5, 16);

      // Reset during the WAIT of the second probe
      fill_ramp();
      @(negedge clk);
      A = 8'd22; lb_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_loc", 32'(loc), 32'd0);
      chk("abort_found", 32'(found), 32'd0);
      @(negedge clk);
      chk("abort_stays_idle", 32'(busy), 32'd0);
      run_search("after_abort", 8'd22, 1'b0, 1'b1, 6'd11, 16);

      // start held high for 40 cycles
      @(negedge clk);
      A = 8'd200; lb_mode = 1'b0; start = 1'b1;
      rises = 0; first_done = 0; prev_busy = 1'b0; done_dropped = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
         if (done && first_done == 0) first_done = c;
         if (first_done != 0 && !done) done_dropped = 1'b1;
      end
      chk("hold_busy_rises", 32'(rises), 32'd1);
      chk("hold_done_cycle", 32'(first_done), 32'd16);
      chk("hold_done_dropped", 32'(done_dropped), 32'd0);
      chk("hold_done_end", 32'(done), 32'd1);
      chk("hold_loc", 32'(loc), 32'd32);
      start = 1'b0;
      @(negedge clk);
      chk("hold_release_done", 32'(done), 32'd0);
      chk("hold_release_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("hold_no_retrigger", 32'(busy), 32'd0);

      // A / lb_mode / start toggled mid-search
      @(negedge clk);
      A = 8'd22; lb_mode = 1'b0; start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = 1'b0;
         if (cyc == 2) begin start = 1'b1; A = 8'd200; lb_mode = 1'b1; end
         if (cyc == 5) begin A = 8'd0; lb_mode = 1'b0; end
      end while (!done && cyc < 60);
      chk("toggle_done", 32'(done), 32'd1);
      chk("toggle_cycles", 32'(cyc), 32'd16);
      chk("toggle_found", 32'(found), 32'd1);
      chk("toggle_loc", 32'(loc), 32'd11);
      @(negedge clk);
      chk("toggle_idle", 32'(done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
